// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-busy freezes.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
module hazard_ctrl #(
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             BranchTaken_ex,
    input  logic             MemBusy,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Freeze,
    output logic [1:0]       state
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        FREEZE   = 2'd3
    } state_t;

    localparam logic [1:0] PEN_M1 = 2'(BR_PENALTY - 1);

    // Handshake-free block: every output is a level decision for the current cycle;
    // the pipeline registers it drives sample those levels on the next rising edge.
    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    state_t     eff_state;
    logic [1:0] cnt_q, cnt_d;
    logic       lu;
    logic       fire_stall;
    logic       fire_br;

    assign lu = MemRead_ex && (rdAddr_ex != 5'd0) &&
                ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
                 (rs2Used_id && (rs2Addr_id == rdAddr_ex)));

    assign state = state_q;

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        Freeze      = 1'b0;
        state_d     = state_q;
        saved_d     = saved_q;
        cnt_d       = cnt_q;
        fire_stall  = 1'b0;
        fire_br     = 1'b0;
        // On release from a freeze, behave exactly as the state that was interrupted.
        eff_state   = (state_q == FREEZE) ? saved_q : state_q;

        if (!Reset) begin
            state_d = RUN;
            saved_d = RUN;
            cnt_d   = 2'd0;
        end else if (MemBusy) begin
            Freeze      = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            state_d     = FREEZE;
            if (state_q != FREEZE) begin
                saved_d = state_q;
            end
        end else begin
            case (eff_state)
                FLUSH: begin
                    // EX holds a bubble here, so a branch signal is meaningless.
                    IF_ID_Flush = 1'b1;
                    cnt_d       = cnt_q - 2'd1;
                    state_d     = (cnt_q == 2'd1) ? RUN : FLUSH;
                end
                default: begin
                    if (BranchTaken_ex) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        cnt_d       = PEN_M1;
                        state_d     = (BR_PENALTY > 1) ? FLUSH : RUN;
                        fire_br     = 1'b1;
                    end else if (eff_state == LU_STALL) begin
                        state_d = RUN;
                    end else if (lu) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        state_d     = LU_STALL;
                        fire_stall  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (fire_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (fire_br && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
        if (MemBusy && (freeze_cnt_q != '1)) begin
            freeze_cnt_d = freeze_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = fire_stall ^ fire_br;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Decides each cycle whether the PC, IF_ID and ID_EX pipeline registers advance, hold or are flushed to a bubble.
- Handles three hazards: load-use stalls, taken-branch flushes with a configurable penalty, and whole-pipeline freezes while data memory is busy.
- Sits beside the ID stage. Its outputs drive the PC write enable, the IF_ID write/flush and the ID_EX flush (bubble = all control fields zero).

Parameters:
- BR_PENALTY, 1: number of cycles IF_ID_Flush is asserted after a taken branch. Legal range 1..3.
- CNT_W, 16: width of the statistics counters (used only when HAZARD_STATS_EN is defined).

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  synchronous reset, active-low
- MemRead_ex  in  1  instruction in EX is a load
- rdAddr_ex  in  5  destination register of the instruction in EX
- rs1Addr_id  in  5  source 1 of the instruction in ID
- rs2Addr_id  in  5  source 2 of the instruction in ID
- rs1Used_id  in  1  instruction in ID reads rs1
- rs2Used_id  in  1  instruction in ID reads rs2
- BranchTaken_ex  in  1  branch/jump in EX resolved taken
- MemBusy  in  1  data memory not ready; the whole pipeline must hold
- PCWrite  out  1  PC register write enable
- IF_ID_Write  out  1  IF_ID write enable
- IF_ID_Flush  out  1  IF_ID load NOP
- ID_EX_Flush  out  1  ID_EX load bubble
- Freeze  out  1  hold EX_MEM/MEM_WB (global stall)
- state  out  2  FSM state, for debug

Behaviour:
- FSM states:
  - RUN = 0
  - LU_STALL = 1
  - FLUSH = 2
  - FREEZE = 3
- Reset (Reset==0 sampled at a clk edge):
  - state <= RUN; flush counter <= 0.
  - While Reset is low, outputs are PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, Freeze=0.
  - Reset mid-stall or mid-flush aborts the sequence immediately.
- Load-use hit (lu) is true when all of the following hold:
  - MemRead_ex is 1;
  - rdAddr_ex is not 0;
  - (rs1Used_id and rs1Addr_id==rdAddr_ex) or (rs2Used_id and rs2Addr_id==rdAddr_ex).
- Outputs are combinational from state and current inputs, evaluated in priority order:
  1. MemBusy=1 (any state):
     - Freeze=1, PCWrite=0, IF_ID_Write=0, all flushes 0.
     - Next state FREEZE; the flush counter holds its value.
  2. BranchTaken_ex=1 (state RUN or LU_STALL):
     - IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 (the target is loaded).
     - Counter <= BR_PENALTY-1.
     - Next state FLUSH if BR_PENALTY>1, else RUN.
     - A branch takes precedence over a simultaneous lu: the stalled instruction is on the wrong path.
  3. lu=1 (state RUN):
     - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
     - Next state LU_STALL.
  4. State LU_STALL with no MemBusy/branch:
     - Exactly one bubble has been inserted; normal advance (all enables 1, flushes 0).
     - lu is not re-evaluated this cycle.
     - Next state RUN.
  5. State FLUSH:
     - IF_ID_Flush=1, ID_EX_Flush=0, PCWrite=1.
     - Counter decrements each non-frozen cycle; next state RUN when counter==1 before the decrement.
     - BranchTaken_ex is ignored in FLUSH: EX holds a bubble.
  6. State FREEZE with MemBusy=0:
     - Resume the state saved on entry (RUN, LU_STALL or FLUSH) using a 2-bit saved-state register. Outputs this cycle follow the saved state's rules.
     - If BranchTaken_ex=1 on resume from RUN or LU_STALL, rule 2 applies.
  7. Otherwise (RUN, no hazard): PCWrite=1, IF_ID_Write=1, flushes 0, Freeze=0.
- Latency:
  - Hazard response occurs in the same cycle as detection.
  - A single load-use costs exactly 1 bubble.
  - A taken branch costs BR_PENALTY+1 flushed slots: ID_EX once, IF_ID BR_PENALTY times.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs stall_cnt, flush_cnt and freeze_cnt, each CNT_W bits.
  - stall_cnt increments each cycle rule 3 fires.
  - flush_cnt increments each cycle rule 2 fires.
  - freeze_cnt increments each cycle MemBusy=1.
  - All three saturate at all-ones and are cleared by Reset.
- When undefined: the ports and counters are absent; FSM behaviour is identical.

Test Plan:
- Reset=0 for 2 cycles mid-FLUSH -> state=0, PCWrite=1, all flushes 0 at the first cycle after Reset=1.
- MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5 for one cycle -> that cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle state=1 and all enables 1. Repeat with rdAddr_ex=0 -> no stall.
- BranchTaken_ex=1 with BR_PENALTY=3 -> cycle0 both flushes 1; cycles 1-2 IF_ID_Flush=1, ID_EX_Flush=0; cycle3 state=0.
- BranchTaken_ex=1 and lu=1 in the same cycle -> branch response only; state never enters 1.
- MemBusy=1 for 4 cycles during FLUSH (BR_PENALTY=3, counter=2) -> Freeze=1, PCWrite=0 for 4 cycles; on release, 2 more IF_ID_Flush cycles then RUN.
- HAZARD_STATS_EN with CNT_W=2: 5 load-use events -> stall_cnt=3 (saturated).
